// File: rtl/robot_pkg.sv
// Shared definitions for the robot position tracker and the map sensor model.
//   - orientation encodings (north/south/east/west)
//   - tracker FSM state encoding
//   - default map dimensions
//   - next_orientation_left(): one left rotation of the robot heading
package robot_pkg;

  localparam logic [1:0] NORTH = 2'b00;
  localparam logic [1:0] SOUTH = 2'b01;
  localparam logic [1:0] EAST  = 2'b10;
  localparam logic [1:0] WEST  = 2'b11;

  localparam int DEFAULT_ROWS = 10;
  localparam int DEFAULT_COLS = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DONE  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  // Left rotation: north->west->south->east->north.
  function automatic logic [1:0] next_orientation_left(input logic [1:0] cur);
    logic [1:0] res;
    case (cur)
      NORTH:   res = WEST;
      WEST:    res = SOUTH;
      SOUTH:   res = EAST;
      default: res = NORTH;  // EAST
    endcase
    return res;
  endfunction

endpackage

// File: rtl/robot_step_calc.sv
// Combinational single-step model of the robot on the pipe map.
// Given the current position/heading and this cycle's commands, produces
// the position/heading after the step and flags an advance that would
// leave the map. On such a hit the position is returned unchanged.
// Ports:
//   row, col, orient     : current position and heading
//   front, turn          : commands (front has priority over turn)
//   next_row, next_col   : position after the step
//   next_orient          : heading after the step
//   out_of_map_hit       : advance would have left rows 1..ROWS / cols 1..COLS
module robot_step_calc
  import robot_pkg::*;
#(
  parameter int ROWS  = DEFAULT_ROWS,
  parameter int COLS  = DEFAULT_COLS,
  parameter int ROW_W = 6,
  parameter int COL_W = 6
) (
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  input  logic [1:0]       orient,
  input  logic             front,
  input  logic             turn,
  output logic [ROW_W-1:0] next_row,
  output logic [COL_W-1:0] next_col,
  output logic [1:0]       next_orient,
  output logic             out_of_map_hit
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);

  // Bounds are tested on the current value before any arithmetic, so the
  // +/-1 below can never wrap.
  always_comb begin
    next_row       = row;
    next_col       = col;
    next_orient    = orient;
    out_of_map_hit = 1'b0;
    if (front) begin
      case (orient)
        NORTH: begin
          if (row <= ROW_ONE) out_of_map_hit = 1'b1;
          else                next_row = row - ROW_ONE;
        end
        SOUTH: begin
          if (row >= ROW_MAX) out_of_map_hit = 1'b1;
          else                next_row = row + ROW_ONE;
        end
        EAST: begin
          if (col >= COL_MAX) out_of_map_hit = 1'b1;
          else                next_col = col + COL_ONE;
        end
        default: begin  // WEST
          if (col <= COL_ONE) out_of_map_hit = 1'b1;
          else                next_col = col - COL_ONE;
        end
      endcase
    end else if (turn) begin
      next_orient = next_orientation_left(orient);
    end
  end

endmodule

// File: rtl/robot_position_tracker.sv
// Downstream monitor of the pipe-cleaning robot controller.
// Tracks row/column/heading, counts movement cycles and trash removals,
// and raises sticky flags for leaving the map or front+turn together.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   load                  : start pulse (accepted in IDLE, DONE, FAULT)
//   init_row/col/orient   : starting position and heading
//   max_moves             : movement budget (0 -> straight to DONE)
//   front, turn, remove   : robot commands
//   row, col, orient      : tracked position and heading
//   move_count            : RUN cycles elapsed
//   trash_count           : rising edges of remove seen in RUN (saturating)
//   running, done         : FSM in RUN / DONE
//   out_of_map            : sticky, an advance would have left the map
//   illegal_cmd           : sticky, front and turn in the same RUN cycle
module robot_position_tracker
  import robot_pkg::*;
#(
  parameter int ROWS  = DEFAULT_ROWS,
  parameter int COLS  = DEFAULT_COLS,
  parameter int ROW_W = 6,
  parameter int COL_W = 6,
  parameter int CNT_W = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [ROW_W-1:0] init_row,
  input  logic [COL_W-1:0] init_col,
  input  logic [1:0]       init_orient,
  input  logic [CNT_W-1:0] max_moves,
  input  logic             front,
  input  logic             turn,
  input  logic             remove,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic [1:0]       orient,
  output logic [CNT_W-1:0] move_count,
  output logic [CNT_W-1:0] trash_count,
  output logic             running,
  output logic             done,
  output logic             out_of_map,
  output logic             illegal_cmd
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS);

  state_t           state_reg, state_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [1:0]       orient_reg, orient_next;
  logic [CNT_W-1:0] move_count_reg, move_count_next;
  logic [CNT_W-1:0] trash_count_reg, trash_count_next;
  logic [CNT_W-1:0] max_moves_reg, max_moves_next;
  logic             out_of_map_reg, out_of_map_next;
  logic             illegal_reg, illegal_next;
  logic             remove_prev_reg;

  logic [ROW_W-1:0] step_row;
  logic [COL_W-1:0] step_col;
  logic [1:0]       step_orient;
  logic             step_hit;
  logic             init_bad;
  logic             remove_edge;
  logic [CNT_W-1:0] move_inc;

  robot_step_calc #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_step (
    .row            (row_reg),
    .col            (col_reg),
    .orient         (orient_reg),
    .front          (front),
    .turn           (turn),
    .next_row       (step_row),
    .next_col       (step_col),
    .next_orient    (step_orient),
    .out_of_map_hit (step_hit)
  );

  assign init_bad = (init_row == '0) || (init_row > ROW_MAX) ||
                    (init_col == '0) || (init_col > COL_MAX);
  assign remove_edge = remove && !remove_prev_reg;
  assign move_inc    = move_count_reg + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      row_reg         <= '0;
      col_reg         <= '0;
      orient_reg      <= NORTH;
      move_count_reg  <= '0;
      trash_count_reg <= '0;
      max_moves_reg   <= '0;
      out_of_map_reg  <= 1'b0;
      illegal_reg     <= 1'b0;
      remove_prev_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      row_reg         <= row_next;
      col_reg         <= col_next;
      orient_reg      <= orient_next;
      move_count_reg  <= move_count_next;
      trash_count_reg <= trash_count_next;
      max_moves_reg   <= max_moves_next;
      out_of_map_reg  <= out_of_map_next;
      illegal_reg     <= illegal_next;
      // Edge detector runs in every state so a remove held across the
      // load cycle is not seen as a fresh edge in the first RUN cycle.
      remove_prev_reg <= remove;
    end
  end

  always_comb begin
    state_next       = state_reg;
    row_next         = row_reg;
    col_next         = col_reg;
    orient_next      = orient_reg;
    move_count_next  = move_count_reg;
    trash_count_next = trash_count_reg;
    max_moves_next   = max_moves_reg;
    out_of_map_next  = out_of_map_reg;
    illegal_next     = illegal_reg;

    case (state_reg)
      ST_RUN: begin
        row_next        = step_row;
        col_next        = step_col;
        orient_next     = step_orient;
        move_count_next = move_inc;
        if (front && turn) illegal_next = 1'b1;
        if (remove_edge && (trash_count_reg != '1))
          trash_count_next = trash_count_reg + CNT_W'(1);
        // Leaving the map outranks budget exhaustion on the same edge.
        if (step_hit) begin
          out_of_map_next = 1'b1;
          state_next      = ST_FAULT;
        end else if (move_inc == max_moves_reg) begin
          state_next = ST_DONE;
        end
      end
      default: begin  // IDLE, DONE, FAULT: only load is honoured
        if (load) begin
          row_next         = init_row;
          col_next         = init_col;
          orient_next      = init_orient;
          max_moves_next   = max_moves;
          move_count_next  = '0;
          trash_count_next = '0;
          illegal_next     = 1'b0;
          out_of_map_next  = init_bad;
          if (init_bad)             state_next = ST_FAULT;
          else if (max_moves == '0) state_next = ST_DONE;
          else                      state_next = ST_RUN;
        end
      end
    endcase
  end

  assign row         = row_reg;
  assign col         = col_reg;
  assign orient      = orient_reg;
  assign move_count  = move_count_reg;
  assign trash_count = trash_count_reg;
  assign running     = (state_reg == ST_RUN);
  assign done        = (state_reg == ST_DONE);
  assign out_of_map  = out_of_map_reg;
  assign illegal_cmd = illegal_reg;

endmodule

// File: tb/tb_robot_position_tracker.sv
// Directed bench for robot_position_tracker; hand-computed expectations.
module tb_robot_position_tracker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [5:0] init_row = '0;
  logic [5:0] init_col = '0;
  logic [1:0] init_orient = '0;
  logic [8:0] max_moves = '0;
  logic       front = 1'b0;
  logic       turn = 1'b0;
  logic       remove = 1'b0;
  logic [5:0] row;
  logic [5:0] col;
  logic [1:0] orient;
  logic [8:0] move_count;
  logic [8:0] trash_count;
  logic       running;
  logic       done;
  logic       out_of_map;
  logic       illegal_cmd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  robot_position_tracker dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .init_row    (init_row),
    .init_col    (init_col),
    .init_orient (init_orient),
    .max_moves   (max_moves),
    .front       (front),
    .turn        (turn),
    .remove      (remove),
    .row         (row),
    .col         (col),
    .orient      (orient),
    .move_count  (move_count),
    .trash_count (trash_count),
    .running     (running),
    .done        (done),
    .out_of_map  (out_of_map),
    .illegal_cmd (illegal_cmd)
  );

  // One clock; outputs are observed 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [5:0] r, input logic [5:0] c,
                         input logic [1:0] o, input logic [8:0] m);
    init_row = r; init_col = c; init_orient = o; max_moves = m;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (row !== 6'd0) begin miscompares++; $display("FAIL reset_row: got %0d want 0", row); end
    vectors++; if (col !== 6'd0) begin miscompares++; $display("FAIL reset_col: got %0d want 0", col); end
    vectors++; if (orient !== 2'd0) begin miscompares++; $display("FAIL reset_orient: got %0d want 0", orient); end
    vectors++; if (move_count !== 9'd0 || trash_count !== 9'd0) begin miscompares++; $display("FAIL reset_counts: got move=%0d trash=%0d want 0 0", move_count, trash_count); end
    vectors++; if ({running, done, out_of_map, illegal_cmd} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {running, done, out_of_map, illegal_cmd}); end
  endtask

  task automatic test_front_north();
    logic [5:0] exp_row;
    do_load(6'd5, 6'd5, 2'b00, 9'd3);
    vectors++; if (running !== 1'b1 || row !== 6'd5) begin miscompares++; $display("FAIL load_run: got running=%0d row=%0d want 1 5", running, row); end
    front = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_row = 6'(4 - i);
      vectors++; if (row !== exp_row || col !== 6'd5) begin miscompares++; $display("FAIL north_step%0d: got row=%0d col=%0d want %0d 5", i, row, col, exp_row); end
    end
    front = 1'b0;
    vectors++; if (move_count !== 9'd3) begin miscompares++; $display("FAIL north_moves: got %0d want 3", move_count); end
    vectors++; if (done !== 1'b1 || running !== 1'b0) begin miscompares++; $display("FAIL north_done: got done=%0d running=%0d want 1 0", done, running); end
  endtask

  task automatic test_out_of_map();
    do_load(6'd1, 6'd7, 2'b00, 9'd10);
    front = 1'b1;
    step();
    vectors++; if (row !== 6'd1 || out_of_map !== 1'b1) begin miscompares++; $display("FAIL oom_hit: got row=%0d oom=%0d want 1 1", row, out_of_map); end
    vectors++; if (move_count !== 9'd1 || running !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL oom_fault: got moves=%0d running=%0d done=%0d want 1 0 0", move_count, running, done); end
    step();
    step();
    vectors++; if (row !== 6'd1 || move_count !== 9'd1) begin miscompares++; $display("FAIL oom_ignored: got row=%0d moves=%0d want 1 1", row, move_count); end
    front = 1'b0;
  endtask

  task automatic test_turn();
    logic [1:0] exp_o [4];
    exp_o[0] = 2'b00; exp_o[1] = 2'b11; exp_o[2] = 2'b01; exp_o[3] = 2'b10;
    do_load(6'd3, 6'd3, 2'b10, 9'd4);
    vectors++; if (out_of_map !== 1'b0 || move_count !== 9'd0) begin miscompares++; $display("FAIL reload_clear: got oom=%0d moves=%0d want 0 0", out_of_map, move_count); end
    turn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++; if (orient !== exp_o[i] || row !== 6'd3 || col !== 6'd3) begin miscompares++; $display("FAIL turn_step%0d: got o=%0d r=%0d c=%0d want %0d 3 3", i, orient, row, col, exp_o[i]); end
      vectors++; if (done !== (i == 3)) begin miscompares++; $display("FAIL turn_done%0d: got %0d want %0d", i, done, (i == 3)); end
    end
    turn = 1'b0;
  endtask

  task automatic test_illegal();
    do_load(6'd2, 6'd20, 2'b01, 9'd5);
    front = 1'b1; turn = 1'b1;
    step();
    front = 1'b0; turn = 1'b0;
    vectors++; if (row !== 6'd3 || col !== 6'd20 || orient !== 2'b01) begin miscompares++; $display("FAIL illegal_pos: got r=%0d c=%0d o=%0d want 3 20 1", row, col, orient); end
    vectors++; if (illegal_cmd !== 1'b1 || running !== 1'b1) begin miscompares++; $display("FAIL illegal_flag: got ill=%0d running=%0d want 1 1", illegal_cmd, running); end
    step();
    vectors++; if (illegal_cmd !== 1'b1) begin miscompares++; $display("FAIL illegal_sticky: got %0d want 1", illegal_cmd); end
    // Load during RUN must be ignored.
    do_load(6'd7, 6'd7, 2'b00, 9'd9);
    vectors++; if (row !== 6'd3 || move_count !== 9'd3 || running !== 1'b1) begin miscompares++; $display("FAIL load_in_run: got r=%0d moves=%0d running=%0d want 3 3 1", row, move_count, running); end
  endtask

  task automatic test_remove();
    logic pattern [5];
    pattern[0] = 1'b1; pattern[1] = 1'b1; pattern[2] = 1'b1; pattern[3] = 1'b0; pattern[4] = 1'b1;
    do_reset();
    do_load(6'd5, 6'd5, 2'b00, 9'd8);
    for (int i = 0; i < 5; i++) begin
      remove = pattern[i];
      step();
    end
    remove = 1'b0;
    vectors++; if (trash_count !== 9'd2) begin miscompares++; $display("FAIL trash_count: got %0d want 2", trash_count); end
    vectors++; if (move_count !== 9'd5 || running !== 1'b1) begin miscompares++; $display("FAIL trash_moves: got moves=%0d running=%0d want 5 1", move_count, running); end
  endtask

  task automatic test_boundaries();
    do_reset();
    do_load(6'd10, 6'd20, 2'b01, 9'd0);
    vectors++; if (done !== 1'b1 || running !== 1'b0 || row !== 6'd10) begin miscompares++; $display("FAIL zero_budget: got done=%0d running=%0d row=%0d want 1 0 10", done, running, row); end
    // Budget exhausted and south edge hit on the same edge: FAULT wins.
    do_load(6'd10, 6'd1, 2'b01, 9'd1);
    front = 1'b1;
    step();
    front = 1'b0;
    vectors++; if (out_of_map !== 1'b1 || done !== 1'b0 || row !== 6'd10) begin miscompares++; $display("FAIL fault_wins: got oom=%0d done=%0d row=%0d want 1 0 10", out_of_map, done, row); end
    // West edge at col 1.
    do_load(6'd4, 6'd1, 2'b11, 9'd5);
    front = 1'b1;
    step();
    front = 1'b0;
    vectors++; if (out_of_map !== 1'b1 || col !== 6'd1 || running !== 1'b0) begin miscompares++; $display("FAIL west_edge: got oom=%0d col=%0d running=%0d want 1 1 0", out_of_map, col, running); end
    // East step inside the map.
    do_load(6'd4, 6'd19, 2'b10, 9'd5);
    front = 1'b1;
    step();
    front = 1'b0;
    vectors++; if (col !== 6'd20 || out_of_map !== 1'b0) begin miscompares++; $display("FAIL east_step: got col=%0d oom=%0d want 20 0", col, out_of_map); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    do_load(6'd5, 6'd5, 2'b00, 9'd8);
    step();
    step();
    vectors++; if (move_count !== 9'd2) begin miscompares++; $display("FAIL mid_run_moves: got %0d want 2", move_count); end
    reset = 1'b1; load = 1'b1; front = 1'b1;
    init_row = 6'd3; init_col = 6'd3; max_moves = 9'd4;
    step();
    reset = 1'b0; load = 1'b0; front = 1'b0;
    vectors++; if (row !== 6'd0 || col !== 6'd0 || move_count !== 9'd0 || running !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL mid_reset: got r=%0d c=%0d m=%0d run=%0d done=%0d want 0 0 0 0 0", row, col, move_count, running, done); end
    do_load(6'd0, 6'd5, 2'b00, 9'd4);
    vectors++; if (out_of_map !== 1'b1 || running !== 1'b0 || done !== 1'b0 || row !== 6'd0 || col !== 6'd5) begin miscompares++; $display("FAIL bad_init: got oom=%0d run=%0d done=%0d r=%0d c=%0d want 1 0 0 0 5", out_of_map, running, done, row, col); end
  endtask

  initial begin
    test_reset();
    test_front_north();
    test_out_of_map();
    test_turn();
    test_illegal();
    test_remove();
    test_boundaries();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
